// File: rtl/ram_pkg.sv
// Shared types and constants for the SRAM-like request/response memory.
package ram_pkg;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;
  // Fibonacci taps 16,14,13,11 expressed as a mask over bits [15:0]
  localparam logic [15:0] LFSR_TAPS = 16'hB400;

  localparam int unsigned RESP_DATA_W = 32;

  // Response entry layout at the default word width
  typedef struct packed {
    logic                   valid;
    logic                   is_read;
    logic [RESP_DATA_W-1:0] data;
  } resp_t;

  function automatic int unsigned lanes(input int unsigned width);
    return width / 8;
  endfunction

endpackage

// File: rtl/ram_resp_pipe.sv
// Fixed-latency response shift register; entries leave in acceptance order.
module ram_resp_pipe #(
  parameter int unsigned LATENCY = 1,
  parameter int unsigned WIDTH   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic             in_is_read,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic             out_is_read,
  output logic [WIDTH-1:0] out_data
);

  typedef struct packed {
    logic             valid;
    logic             is_read;
    logic [WIDTH-1:0] data;
  } entry_t;

  entry_t stage_q [LATENCY];
  entry_t stage_d [LATENCY];

  always_comb begin
    stage_d[0] = entry_t'{valid: in_valid, is_read: in_is_read, data: in_data};
    for (int unsigned i = 1; i < LATENCY; i++) begin
      stage_d[i] = stage_q[i-1];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < LATENCY; i++) begin
        stage_q[i] <= '0;
      end
    end else begin
      stage_q <= stage_d;
    end
  end

  always_comb begin
    out_valid   = stage_q[LATENCY-1].valid;
    out_is_read = stage_q[LATENCY-1].is_read;
    out_data    = stage_q[LATENCY-1].data;
  end

endmodule

// File: rtl/sram_like_ram.sv
// On-chip RAM with pipelined req/addr_ok, data_ok handshake, byte strobes,
// bounded outstanding requests and optional LFSR stall injection.
module sram_like_ram
  import ram_pkg::*;
#(
  parameter int unsigned DEPTH           = 65536,
  parameter int unsigned WIDTH           = 32,
  parameter int unsigned LATENCY         = 1,
  parameter int unsigned MAX_OUTSTANDING = 2,
  parameter int unsigned STALL_EN        = 0,
  localparam int unsigned LANES          = lanes(WIDTH),
  localparam int unsigned ADDR_W         = $clog2(DEPTH) + $clog2(LANES)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req,
  input  logic              wr,
  input  logic [LANES-1:0]  wstrb,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WIDTH-1:0]  wdata,
  output logic              addr_ok,
  output logic              data_ok,
  output logic [WIDTH-1:0]  rdata
);

  localparam int unsigned OFF_W = $clog2(LANES);
  localparam int unsigned IDX_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(MAX_OUTSTANDING + 1);

  logic [IDX_W-1:0] idx;
  logic [WIDTH-1:0] rd_word;
  logic             accept;
  logic             resp_now;
  logic             pipe_is_read;
  logic [WIDTH-1:0] pipe_data;
  logic [CNT_W-1:0] count_q, count_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             unused_addr_bits;

  assign idx              = addr[ADDR_W-1:OFF_W];
  assign unused_addr_bits = ^addr;

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    logic [7:0] mem [DEPTH];

    always_ff @(posedge clk) begin
      if (accept && wr && wstrb[i]) begin
        mem[idx] <= wdata[8*i +: 8];
      end
    end

    assign rd_word[8*i +: 8] = mem[idx];
  end

  // Held low through reset so nothing is accepted while state is being cleared
  always_comb begin
    addr_ok = !rst
           && ((count_q < CNT_W'(MAX_OUTSTANDING)) || resp_now)
           && ((STALL_EN == 0) || lfsr_q[0]);
  end

  assign accept = req && addr_ok;

  ram_resp_pipe #(
    .LATENCY (LATENCY),
    .WIDTH   (WIDTH)
  ) u_resp_pipe (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (accept),
    .in_is_read  (!wr),
    .in_data     (wr ? '0 : rd_word),
    .out_valid   (resp_now),
    .out_is_read (pipe_is_read),
    .out_data    (pipe_data)
  );

  always_comb begin
    data_ok = resp_now;
    rdata   = (resp_now && pipe_is_read) ? pipe_data : '0;
  end

  always_comb begin
    count_d = count_q;
    case ({accept, resp_now})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase
  end

  always_comb begin
    lfsr_d = lfsr_q;
    if (STALL_EN != 0) begin
      lfsr_d = {lfsr_q[14:0], ^(lfsr_q & LFSR_TAPS)};
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_q <= '0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      count_q <= count_d;
      lfsr_q  <= lfsr_d;
    end
  end

endmodule

// File: tb/tb_sram_like_ram.sv
// Directed and scoreboarded checks of sram_like_ram across four configurations.
module tb_sram_like_ram;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic [3:0]  wr;
  logic [3:0]  addr_ok;
  logic [3:0]  data_ok;
  logic [3:0]  wstrb [4];
  logic [9:0]  addr  [4];
  logic [31:0] wdata [4];
  logic [31:0] rdata [4];

  int n_cmp = 0;
  int n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  sram_like_ram #(.DEPTH(256), .WIDTH(32), .LATENCY(1), .MAX_OUTSTANDING(2), .STALL_EN(0)) dut_a (
    .clk(clk), .rst(rst), .req(req[0]), .wr(wr[0]), .wstrb(wstrb[0]), .addr(addr[0]),
    .wdata(wdata[0]), .addr_ok(addr_ok[0]), .data_ok(data_ok[0]), .rdata(rdata[0]));

  sram_like_ram #(.DEPTH(256), .WIDTH(32), .LATENCY(3), .MAX_OUTSTANDING(2), .STALL_EN(0)) dut_b (
    .clk(clk), .rst(rst), .req(req[1]), .wr(wr[1]), .wstrb(wstrb[1]), .addr(addr[1]),
    .wdata(wdata[1]), .addr_ok(addr_ok[1]), .data_ok(data_ok[1]), .rdata(rdata[1]));

  sram_like_ram #(.DEPTH(256), .WIDTH(32), .LATENCY(2), .MAX_OUTSTANDING(1), .STALL_EN(0)) dut_c (
    .clk(clk), .rst(rst), .req(req[2]), .wr(wr[2]), .wstrb(wstrb[2]), .addr(addr[2]),
    .wdata(wdata[2]), .addr_ok(addr_ok[2]), .data_ok(data_ok[2]), .rdata(rdata[2]));

  sram_like_ram #(.DEPTH(256), .WIDTH(32), .LATENCY(2), .MAX_OUTSTANDING(2), .STALL_EN(1)) dut_d (
    .clk(clk), .rst(rst), .req(req[3]), .wr(wr[3]), .wstrb(wstrb[3]), .addr(addr[3]),
    .wdata(wdata[3]), .addr_ok(addr_ok[3]), .data_ok(data_ok[3]), .rdata(rdata[3]));

  task automatic do_write(input int d, input logic [9:0] a, input logic [31:0] v);
    bit acc  = 1'b0;
    bit done = 1'b0;
    req[d] = 1'b1; wr[d] = 1'b1; wstrb[d] = 4'hF; addr[d] = a; wdata[d] = v;
    for (int t = 0; t < 40 && !done; t++) begin
      if (!acc && addr_ok[d]) acc = 1'b1;
      @(negedge clk);
      if (acc) req[d] = 1'b0;
      if (acc && data_ok[d]) done = 1'b1;
    end
    req[d] = 1'b0;
    n_cmp++;
    if (done !== 1'b1) begin
      n_bad++;
      $display("FAIL write_timeout dut%0d: done=%0b want 1", d, done);
    end
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    req = '0; wr = '0;
    for (int d = 0; d < 4; d++) begin
      wstrb[d] = '0; addr[d] = '0; wdata[d] = '0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 4; d++) begin
      n_cmp++;
      if (addr_ok[d] !== 1'b0) begin n_bad++; $display("FAIL reset_addr_ok dut%0d: got %b want 0", d, addr_ok[d]); end
      n_cmp++;
      if (data_ok[d] !== 1'b0) begin n_bad++; $display("FAIL reset_data_ok dut%0d: got %b want 0", d, data_ok[d]); end
      n_cmp++;
      if (rdata[d] !== 32'h0) begin n_bad++; $display("FAIL reset_rdata dut%0d: got %h want 0", d, rdata[d]); end
    end
    rst = 1'b0;
    #1;
    n_cmp++;
    if (addr_ok[0] !== 1'b1) begin n_bad++; $display("FAIL post_reset_addr_ok dut0: got %b want 1", addr_ok[0]); end
    n_cmp++;
    if (addr_ok[3] !== 1'b1) begin n_bad++; $display("FAIL post_reset_addr_ok dut3: got %b want 1", addr_ok[3]); end
    @(negedge clk);
  endtask

  task automatic test_write_read();
    req[0] = 1'b1; wr[0] = 1'b1; wstrb[0] = 4'b1111; addr[0] = 10'h010; wdata[0] = 32'hDEADBEEF;
    n_cmp++;
    if (addr_ok[0] !== 1'b1) begin n_bad++; $display("FAIL wr_accept: got %b want 1", addr_ok[0]); end
    @(negedge clk);
    n_cmp++;
    if (data_ok[0] !== 1'b1 || rdata[0] !== 32'h0) begin
      n_bad++; $display("FAIL wr_resp: data_ok=%b rdata=%h want 1/00000000", data_ok[0], rdata[0]);
    end
    wr[0] = 1'b0; addr[0] = 10'h010;
    @(negedge clk);
    n_cmp++;
    if (data_ok[0] !== 1'b1 || rdata[0] !== 32'hDEADBEEF) begin
      n_bad++; $display("FAIL raw_read: data_ok=%b rdata=%h want 1/deadbeef", data_ok[0], rdata[0]);
    end
    req[0] = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (data_ok[0] !== 1'b0) begin n_bad++; $display("FAIL idle_data_ok: got %b want 0", data_ok[0]); end
  endtask

  task automatic test_byte_lanes();
    logic        t_wr   [5] = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
    logic [3:0]  t_strb [5] = '{4'b0100, 4'b0000, 4'b0000, 4'b0000, 4'b1111};
    logic [9:0]  t_addr [5] = '{10'h010, 10'h010, 10'h013, 10'h010, 10'h010};
    logic [31:0] t_data [5] = '{32'h00AA0000, 32'h0, 32'h0, 32'hFFFFFFFF, 32'h0};
    logic [31:0] t_exp  [5] = '{32'h0, 32'hDEAABEEF, 32'hDEAABEEF, 32'h0, 32'hDEAABEEF};
    for (int k = 0; k < 5; k++) begin
      req[0] = 1'b1; wr[0] = t_wr[k]; wstrb[0] = t_strb[k]; addr[0] = t_addr[k]; wdata[0] = t_data[k];
      @(negedge clk);
      n_cmp++;
      if (data_ok[0] !== 1'b1 || rdata[0] !== t_exp[k]) begin
        n_bad++; $display("FAIL byte_lane[%0d]: data_ok=%b rdata=%h want 1/%h", k, data_ok[0], rdata[0], t_exp[k]);
      end
    end
    req[0] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_latency3();
    int          exp_acc  [4] = '{0, 1, 3, 4};
    int          exp_resp [4] = '{3, 4, 6, 7};
    logic [31:0] exp_data [4] = '{32'hA5A50000, 32'hA5A50001, 32'hA5A50002, 32'hA5A50003};
    int issued = 0;
    int got    = 0;
    do_write(1, 10'h000, 32'hA5A50000);
    do_write(1, 10'h004, 32'hA5A50001);
    do_write(1, 10'h008, 32'hA5A50002);
    do_write(1, 10'h00C, 32'hA5A50003);
    for (int t = 0; t < 12; t++) begin
      if (data_ok[1]) begin
        n_cmp++;
        if (got >= 4 || rdata[1] !== exp_data[got] || t !== exp_resp[got]) begin
          n_bad++; $display("FAIL lat3_resp[%0d]: rdata=%h cycle=%0d", got, rdata[1], t);
        end
        got++;
      end
      if (t == 2) begin
        n_cmp++;
        if (addr_ok[1] !== 1'b0) begin n_bad++; $display("FAIL lat3_full: addr_ok=%b want 0", addr_ok[1]); end
      end
      if (issued < 4) begin
        req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 10'(4 * issued);
        if (addr_ok[1]) begin
          n_cmp++;
          if (t !== exp_acc[issued]) begin
            n_bad++; $display("FAIL lat3_accept[%0d]: cycle=%0d want %0d", issued, t, exp_acc[issued]);
          end
          issued++;
        end
      end else begin
        req[1] = 1'b0;
      end
      @(negedge clk);
    end
    req[1] = 1'b0;
    n_cmp++;
    if (got !== 4) begin n_bad++; $display("FAIL lat3_count: responses=%0d want 4", got); end
  endtask

  task automatic test_backpressure();
    int exp_acc  [4] = '{0, 2, 4, 6};
    int exp_resp [4] = '{2, 4, 6, 8};
    int issued  = 0;
    int got     = 0;
    int max_out = 0;
    for (int t = 0; t < 12; t++) begin
      if (data_ok[2]) begin
        n_cmp++;
        if (got >= 4 || t !== exp_resp[got]) begin
          n_bad++; $display("FAIL bp_resp[%0d]: cycle=%0d", got, t);
        end
        got++;
      end
      if (issued < 4) begin
        req[2] = 1'b1; wr[2] = 1'b0; addr[2] = 10'(4 * issued);
        if (addr_ok[2]) begin
          n_cmp++;
          if (t !== exp_acc[issued]) begin
            n_bad++; $display("FAIL bp_accept[%0d]: cycle=%0d want %0d", issued, t, exp_acc[issued]);
          end
          issued++;
        end
      end else begin
        req[2] = 1'b0;
      end
      if (issued - got > max_out) max_out = issued - got;
      @(negedge clk);
    end
    req[2] = 1'b0;
    n_cmp++;
    if (max_out !== 1 || got !== 4) begin
      n_bad++; $display("FAIL bp_outstanding: max=%0d responses=%0d want 1/4", max_out, got);
    end
  endtask

  task automatic test_reset_midflight();
    int seen = 0;
    do_write(1, 10'h020, 32'h12345678);
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 10'h020;
    n_cmp++;
    if (addr_ok[1] !== 1'b1) begin n_bad++; $display("FAIL mid_accept: addr_ok=%b want 1", addr_ok[1]); end
    @(negedge clk);
    req[1] = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (data_ok[1] !== 1'b0 || addr_ok[1] !== 1'b0) begin
      n_bad++; $display("FAIL mid_in_reset: data_ok=%b addr_ok=%b want 0/0", data_ok[1], addr_ok[1]);
    end
    rst = 1'b0;
    for (int t = 0; t < 8; t++) begin
      @(negedge clk);
      if (data_ok[1]) seen++;
    end
    n_cmp++;
    if (seen !== 0) begin n_bad++; $display("FAIL mid_discard: data_ok pulses=%0d want 0", seen); end
    req[1] = 1'b1; wr[1] = 1'b0; addr[1] = 10'h020;
    n_cmp++;
    if (addr_ok[1] !== 1'b1) begin n_bad++; $display("FAIL mid_reaccept: addr_ok=%b want 1", addr_ok[1]); end
    @(negedge clk);
    req[1] = 1'b0;
    repeat (2) @(negedge clk);
    n_cmp++;
    if (data_ok[1] !== 1'b1 || rdata[1] !== 32'h12345678) begin
      n_bad++; $display("FAIL mid_persist: data_ok=%b rdata=%h want 1/12345678", data_ok[1], rdata[1]);
    end
    @(negedge clk);
  endtask

  task automatic test_stall_random();
    logic [31:0] model [16];
    logic [31:0] expq  [$];
    logic [31:0] e;
    logic [31:0] v;
    logic [3:0]  s;
    logic        w;
    int word;
    int sent   = 0;
    int low    = 0;
    int cycles = 0;
    for (int cyc = 0; cyc < 20000 && (sent < 1000 || expq.size() > 0); cyc++) begin
      if (data_ok[3]) begin
        n_cmp++;
        if (expq.size() == 0) begin
          n_bad++; $display("FAIL stall_extra_resp: cycle=%0d rdata=%h with empty scoreboard", cyc, rdata[3]);
        end else begin
          e = expq.pop_front();
          if (rdata[3] !== e) begin
            n_bad++; $display("FAIL stall_data: cycle=%0d rdata=%h want %h", cyc, rdata[3], e);
          end
        end
      end
      if (!addr_ok[3]) low++;
      cycles++;
      if (sent < 1000 && $urandom_range(3) != 0) begin
        if (sent < 16) begin
          w = 1'b1; s = 4'hF; word = sent;
        end else begin
          w = 1'($urandom_range(1)); s = 4'($urandom_range(15)); word = int'($urandom_range(15));
        end
        v = $urandom;
        req[3] = 1'b1; wr[3] = w; wstrb[3] = s; wdata[3] = v;
        addr[3] = 10'(word * 4 + ((sent < 16) ? 0 : int'($urandom_range(3))));
        if (addr_ok[3]) begin
          if (w) begin
            expq.push_back(32'h0);
            for (int i = 0; i < 4; i++) if (s[i]) model[word][8*i +: 8] = v[8*i +: 8];
          end else begin
            expq.push_back(model[word]);
          end
          sent++;
        end
      end else begin
        req[3] = 1'b0;
      end
      @(negedge clk);
    end
    req[3] = 1'b0;
    n_cmp++;
    if (sent !== 1000 || expq.size() !== 0) begin
      n_bad++; $display("FAIL stall_lost: sent=%0d outstanding=%0d want 1000/0", sent, expq.size());
    end
    n_cmp++;
    if (low * 100 < cycles * 30 || low * 100 > cycles * 70) begin
      n_bad++; $display("FAIL stall_ratio: addr_ok low %0d of %0d cycles, want 30-70%%", low, cycles);
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_latency3();
    test_backpressure();
    test_reset_midflight();
    test_stall_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
